ps2_key_ctrl: RTL

Receive controller for the PS/2 keyboard port. It synchronises `ps2_clk` and `ps2_data`, runs the 11-bit frame state machine (start, 8 data bits, odd parity, stop) and checks each frame. It then folds the `E0` (extended) and `F0` (break) prefix bytes into single key events and buffers them in a small FIFO. Downstream logic, such as the VGA colour logic, consumes events through a valid/ready handshake.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_evt_fifo.sv | 56 +++++
 rtl/ps2_key_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
// Used by ps2_key_ctrl and ps2_evt_fifo.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
   localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } ps2_evt_t;

   // Odd parity holds when data plus parity bit carry an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Key-event FIFO; DEPTH must be a power of 2 (>= 2). The head entry reads as
// all-zero while the FIFO is empty so downstream outputs are 0 after reset.
module ps2_evt_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  ps2_evt_t push_data,
   input  logic     pop,
   output ps2_evt_t head,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   ps2_evt_t      mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          wr_en;
   logic          rd_en;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   // A push into a full FIFO is still accepted when the head leaves this cycle.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
   end

   assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receiver: synchroniser, 11-bit frame FSM, E0/F0 prefix decoder
// and event FIFO. Define PS2_TIMEOUT_EN to abandon stalled partial frames.
module ps2_key_ctrl
   import ps2_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_break,
   output logic       frame_err,
   output logic       overrun
);

   logic       clk_s1, clk_s2, clk_s3;
   logic       dat_s1, dat_s2;
   logic       fall;
   ps2_state_t state, state_nx;
   logic [2:0] bit_cnt, bit_cnt_nx;
   logic [7:0] shreg, shreg_nx;
   logic       par_bit, par_bit_nx;
   logic       byte_ok, byte_bad;
   logic       timeout;
   logic       ext_f, brk_f;
   logic       push, pop, full, empty;
   ps2_evt_t   push_data, head;

   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_s3 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   assign fall = clk_s3 && !clk_s2;

`ifdef PS2_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0] to_cnt;

   always_ff @(posedge clk) begin
      if (!rst || state == IDLE || fall) to_cnt <= '0;
      else                               to_cnt <= to_cnt + 1'b1;
   end

   assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else begin
         state   <= state_nx;
         bit_cnt <= bit_cnt_nx;
         shreg   <= shreg_nx;
         par_bit <= par_bit_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      bit_cnt_nx = bit_cnt;
      shreg_nx   = shreg;
      par_bit_nx = par_bit;
      byte_ok    = 1'b0;
      byte_bad   = 1'b0;
      if (fall) begin
         case (state)
            IDLE: begin
               if (!dat_s2) begin
                  state_nx   = DATA;
                  bit_cnt_nx = '0;
               end
            end
            DATA: begin
               shreg_nx   = {dat_s2, shreg[7:1]};
               bit_cnt_nx = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) state_nx = PARITY;
            end
            PARITY: begin
               par_bit_nx = dat_s2;
               state_nx   = STOP;
            end
            STOP: begin
               state_nx = IDLE;
               if (dat_s2 && odd_parity_ok(shreg, par_bit)) byte_ok  = 1'b1;
               else                                         byte_bad = 1'b1;
            end
            default: state_nx = IDLE;
         endcase
      end
      if (timeout) begin
         state_nx = IDLE;
         byte_ok  = 1'b0;
         byte_bad = 1'b1;
      end
   end

   // Prefix bytes only arm flags; the next ordinary byte carries them out.
   assign push = byte_ok && (shreg != PS2_EXT_CODE) && (shreg != PS2_BRK_CODE);
   assign push_data = '{code: shreg, ext: ext_f, brk: brk_f};

   always_ff @(posedge clk) begin
      if (!rst || byte_bad) begin
         ext_f <= 1'b0;
         brk_f <= 1'b0;
      end else if (byte_ok) begin
         if (shreg == PS2_EXT_CODE) begin
            ext_f <= 1'b1;
         end else if (shreg == PS2_BRK_CODE) begin
            brk_f <= 1'b1;
         end else begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= byte_bad;
         overrun   <= push && full && !pop;
      end
   end

   // Handshake: the head event transfers on any clk edge where evt_valid and
   // evt_ready are both high; evt_* hold steady until that transfer.
   assign pop = evt_ready && !empty;

   ps2_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   assign evt_valid = !empty;
   assign evt_code  = head.code;
   assign evt_ext   = head.ext;
   assign evt_break = head.brk;

endmodule
